// File: rtl/matvec_engine.sv
// Matrix-vector multiply engine.
// Reads an N x N matrix row-major from an external synchronous RAM, multiplies
// it by a vector captured at start, and streams out one result per row.
//
// Result handshake: a row transfers on any rising edge where res_valid and
// res_ready are both 1. Once res_valid is raised, res_data/res_idx hold their
// values until that transfer happens; res_valid never drops without a transfer
// (except on reset).
module matvec_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int N          = 4,
  parameter int DEPTH      = 16,
  localparam int ADDR_WIDTH = $clog2(DEPTH),
  localparam int IDX_WIDTH  = $clog2(N),
  localparam int RES_WIDTH  = 2 * DATA_WIDTH + $clog2(N)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [N*DATA_WIDTH-1:0] vec_in,
  output logic                    ram_rd_en,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  input  logic [DATA_WIDTH-1:0]   ram_rd_data,
  output logic [RES_WIDTH-1:0]    res_data,
  output logic [IDX_WIDTH-1:0]    res_idx,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic                    busy,
  output logic                    done,
  output logic [2:0]              dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    DRAIN = 3'd2,
    EMIT  = 3'd3,
    FIN   = 3'd4
  } state_t;

  state_t                  state;
  logic [N*DATA_WIDTH-1:0] vec_reg;
  logic [RES_WIDTH-1:0]    acc [N];

  // Read pipeline: address issued last cycle, whose data is on ram_rd_data now
  logic                    p_valid;
  logic [ADDR_WIDTH-1:0]   p_addr;
  logic [IDX_WIDTH-1:0]    p_row;
  logic [IDX_WIDTH-1:0]    p_col;
  logic [DATA_WIDTH-1:0]   vec_elem;
  logic [RES_WIDTH-1:0]    product;
  logic                    start_accept;

  assign start_accept = (state == IDLE) && start;
  assign busy         = (state != IDLE);
  assign dbg_state    = state;

  assign p_row    = IDX_WIDTH'(p_addr / ADDR_WIDTH'(N));
  assign p_col    = IDX_WIDTH'(p_addr % ADDR_WIDTH'(N));
  assign vec_elem = vec_reg[p_col*DATA_WIDTH +: DATA_WIDTH];
  assign product  = RES_WIDTH'(ram_rd_data) * RES_WIDTH'(vec_elem);

  // Vector capture, read-data pipeline tracking and row accumulation
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_valid <= 1'b0;
      p_addr  <= '0;
      vec_reg <= '0;
      for (int i = 0; i < N; i++) acc[i] <= '0;
    end else begin
      p_valid <= ram_rd_en;
      p_addr  <= ram_addr;
      if (start_accept) begin
        vec_reg <= vec_in;
        for (int i = 0; i < N; i++) acc[i] <= '0;
      end else if (p_valid) begin
        acc[p_row] <= acc[p_row] + product;
      end
    end
  end

  // Control FSM with registered RAM strobe, result and completion outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ram_rd_en <= 1'b0;
      ram_addr  <= '0;
      res_data  <= '0;
      res_idx   <= '0;
      res_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state     <= READ;
            ram_rd_en <= 1'b1;
            ram_addr  <= '0;
          end
        end
        READ: begin
          if (ram_addr == ADDR_WIDTH'(DEPTH - 1)) begin
            state     <= DRAIN;
            ram_rd_en <= 1'b0;
            ram_addr  <= '0;
          end else begin
            ram_addr <= ram_addr + 1'b1;
          end
        end
        DRAIN: begin
          // Final read word is absorbed into the accumulators this cycle
          state   <= EMIT;
          res_idx <= '0;
        end
        EMIT: begin
          if (!res_valid) begin
            res_valid <= 1'b1;
            res_data  <= acc[res_idx];
          end else if (res_ready) begin
            if (res_idx == IDX_WIDTH'(N - 1)) begin
              state     <= FIN;
              res_valid <= 1'b0;
              res_data  <= '0;
              res_idx   <= '0;
              done      <= 1'b1;
            end else begin
              res_idx  <= res_idx + 1'b1;
              res_data <= acc[IDX_WIDTH'(res_idx + 1'b1)];
            end
          end
        end
        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
